// File: rtl/btn_evt_pkg.sv
// Shared types and timing windows for the button gesture controller.
// SIM values shrink the windows so gestures complete in tens of cycles.
package btn_evt_pkg;

   localparam int CNT_W = 26;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      WAIT2  = 3'd2,
      PRESS2 = 3'd3,
      LONG   = 3'd4
   } state_e;

`ifdef SIM
   localparam logic [CNT_W-1:0] T_LONG_DEF = 26'd15;
   localparam logic [CNT_W-1:0] T_DBL_DEF  = 26'd8;
   localparam logic [CNT_W-1:0] T_RPT_DEF  = 26'd4;
`else
   localparam logic [CNT_W-1:0] T_LONG_DEF = 26'h2FA_F080;
   localparam logic [CNT_W-1:0] T_DBL_DEF  = 26'h0E4_E1C0;
   localparam logic [CNT_W-1:0] T_RPT_DEF  = 26'h098_9680;
`endif

endpackage

// File: rtl/btn_event_ctrl.sv
// Classifies debounced presses into short / double / long gestures plus auto-repeat.
// Pulses are registered (one cycle); no backpressure, din is sampled every cycle.
module btn_event_ctrl
   import btn_evt_pkg::*;
#(
   parameter logic [CNT_W-1:0] T_LONG = T_LONG_DEF,
   parameter logic [CNT_W-1:0] T_DBL  = T_DBL_DEF,
   parameter logic [CNT_W-1:0] T_RPT  = T_RPT_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic din,
   output logic short_p,
   output logic dbl_p,
   output logic long_p,
   output logic rpt_p,
   output logic hold,
   output logic busy
);

   localparam logic [CNT_W-1:0] LONG_LAST = T_LONG - 1'b1;
   localparam logic [CNT_W-1:0] DBL_LAST  = T_DBL - 1'b1;
   localparam logic [CNT_W-1:0] RPT_LAST  = T_RPT - 1'b1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              din_prev_q, din_prev_d;
   logic              short_q, short_d;
   logic              dbl_q, dbl_d;
   logic              long_q, long_d;
   logic              rpt_q, rpt_d;
   logic              rise;

   assign rise = din & ~din_prev_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      din_prev_d = din;
      short_d    = 1'b0;
      dbl_d      = 1'b0;
      long_d     = 1'b0;
      rpt_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rise) state_d = PRESS1;
         end
         PRESS1: begin
            // Release wins over the threshold so a borderline press stays short.
            if (!din) begin
               state_d = WAIT2;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT2: begin
            if (rise) begin
               state_d = PRESS2;
            end else if (cnt_q == DBL_LAST) begin
               state_d = IDLE;
               short_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESS2: begin
            if (!din) begin
               state_d = IDLE;
               dbl_d   = 1'b1;
            end
         end
         LONG: begin
            if (!din) begin
               state_d = IDLE;
            end else if (cnt_q == RPT_LAST) begin
               rpt_d = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Every window starts from zero on the cycle its state is entered.
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         din_prev_q <= 1'b1;
         short_q    <= 1'b0;
         dbl_q      <= 1'b0;
         long_q     <= 1'b0;
         rpt_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         din_prev_q <= din_prev_d;
         short_q    <= short_d;
         dbl_q      <= dbl_d;
         long_q     <= long_d;
         rpt_q      <= rpt_d;
      end
   end

   assign short_p = short_q;
   assign dbl_p   = dbl_q;
   assign long_p  = long_q;
   assign rpt_p   = rpt_q;
   assign hold    = (state_q == LONG);
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench: stimulus queues (pulse kind, edge index) pairs, a negedge monitor pops them.
// Edge index = count of rising edges so far; an output seen at a negedge belongs to the latest edge.
module tb_btn_event_ctrl;

   localparam int K_SHORT = 0;
   localparam int K_DBL   = 1;
   localparam int K_LONG  = 2;
   localparam int K_RPT   = 3;

   typedef struct {
      int kind;
      int edge_no;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst;
   logic din;
   logic short_p, dbl_p, long_p, rpt_p, hold, busy;

   int   edge_n   = 0;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   btn_event_ctrl #(
      .T_LONG(26'd15),
      .T_DBL (26'd8),
      .T_RPT (26'd4)
   ) dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .din    (din),
      .short_p(short_p),
      .dbl_p  (dbl_p),
      .long_p (long_p),
      .rpt_p  (rpt_p),
      .hold   (hold),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Monitor: every pulse must match the head of the expectation queue.
   always @(negedge clk) begin : monitor
      logic [3:0] p;
      exp_t       e;
      p = {rpt_p, long_p, dbl_p, short_p};
      for (int k = 0; k < 4; k++) begin
         if (p[k]) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pulse kind=%0d edge=%0d, required no pulse", k, edge_n);
            end else begin
               e = sb_q.pop_front();
               if (e.kind != k || e.edge_no != edge_n) begin
                  failures++;
                  $display("FAIL pulse_match got kind=%0d edge=%0d, required kind=%0d edge=%0d",
                           k, edge_n, e.kind, e.edge_no);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic expect_pulse(input int kind, input int edge_no);
      exp_t e;
      e.kind    = kind;
      e.edge_no = edge_no;
      sb_q.push_back(e);
   endtask

   // Called at a negedge: din takes value v for the next n rising edges.
   // Returns the index of the first edge that samples v.
   task automatic drive(input logic v, input int n, output int first);
      din   = v;
      first = edge_n + 1;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_quiet(input string name);
      chk({name, "_pulses"}, int'({short_p, dbl_p, long_p, rpt_p}), 0);
      chk({name, "_hold"}, int'(hold), 0);
      chk({name, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int r, s, d;

      n_rst = 1'b0;
      din   = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_quiet("reset");
      n_rst = 1'b1;
      drive(1'b0, 2, d);

      // Short press: release sampled at s, short_p at s+8.
      drive(1'b1, 5, r);
      s = edge_n + 1;
      expect_pulse(K_SHORT, s + 8);
      drive(1'b0, 20, d);
      chk("short_busy_after", int'(busy), 0);

      // Double click: dbl_p on the edge that samples the second release.
      drive(1'b1, 3, r);
      chk("dbl_busy_pressed", int'(busy), 1);
      drive(1'b0, 4, d);
      drive(1'b1, 3, r);
      s = edge_n + 1;
      expect_pulse(K_DBL, s);
      drive(1'b0, 12, d);

      // Long press held 30 edges: long at r+15, repeats every 4 edges after.
      r = edge_n + 1;
      expect_pulse(K_LONG, r + 15);
      expect_pulse(K_RPT,  r + 19);
      expect_pulse(K_RPT,  r + 23);
      expect_pulse(K_RPT,  r + 27);
      drive(1'b1, 30, d);
      chk("long_hold_held", int'(hold), 1);
      chk("long_busy_held", int'(busy), 1);
      drive(1'b0, 1, d);
      chk("long_hold_release", int'(hold), 0);
      chk("long_busy_release", int'(busy), 0);
      drive(1'b0, 10, d);

      // Release on the edge where cnt==14: stays a short press.
      drive(1'b1, 15, r);
      s = edge_n + 1;
      expect_pulse(K_SHORT, s + 8);
      drive(1'b0, 20, d);

      // Second rise on the edge where cnt==7 in WAIT2: double click.
      drive(1'b1, 3, r);
      drive(1'b0, 8, d);
      drive(1'b1, 2, r);
      s = edge_n + 1;
      expect_pulse(K_DBL, s);
      drive(1'b0, 12, d);

      // Button held through reset: no gesture until a release and fresh press.
      n_rst = 1'b0;
      din   = 1'b1;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      drive(1'b1, 20, d);
      chk("held_reset_busy", int'(busy), 0);
      drive(1'b0, 3, d);
      drive(1'b1, 4, r);
      s = edge_n + 1;
      expect_pulse(K_SHORT, s + 8);
      drive(1'b0, 15, d);

      // Reset mid-LONG aborts with everything cleared on the reset edge.
      r = edge_n + 1;
      expect_pulse(K_LONG, r + 15);
      expect_pulse(K_RPT,  r + 19);
      drive(1'b1, 20, d);
      chk("midlong_hold_before", int'(hold), 1);
      n_rst = 1'b0;
      @(negedge clk);
      chk_all_quiet("midlong_reset");
      n_rst = 1'b1;
      drive(1'b1, 6, d);
      chk("midlong_busy_after", int'(busy), 0);
      drive(1'b0, 15, d);

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
